pipe_skid_reg: RTL
==================

# pipe_skid_reg

Parametrised elastic pipeline stage register with a valid/ready handshake, a two-entry skid buffer, synchronous flush and freeze, and saturating event counters. It replaces the fixed-width, handshake-less stage registers between pipeline stages (IF/ID, ID/EX, EX/MEM, MEM/WB). Back-pressure from a downstream stage is absorbed without a combinational ready path running through the pipeline. Hazard control keeps its existing freeze/flush semantics.

## Interface
- DATA_W, 64, payload width (e.g. {pc, instruction} for IF/ID)
- FLUSH_VAL, {DATA_W{1'b0}}, value loaded into both data registers on reset and on flush
- CNT_W, 16, width of the stall and flush counters

- clk  in  1  clock, all logic on posedge
- rst  in  1  reset, asynchronous, active-high
- in_valid  in  1  upstream beat valid
- in_ready  out  1  stage can accept a beat
- in_data  in  DATA_W  upstream payload
- out_valid  out  1  beat presented downstream
- out_ready  in  1  downstream accepts the beat
- out_data  out  DATA_W  payload of the head entry
- flush  in  1  discard all held entries and the incoming beat
- freeze  in  1  hold all state; no transfer on either side
- occupancy  out  2  number of held entries (0..2)
- stall_cnt  out  CNT_W  saturating count of stall cycles
- flush_cnt  out  CNT_W  saturating count of effective flushes

## Operation
- Storage is a main (head) register and a skid register, each with DATA_W data and a valid bit. The state is EMPTY (0 entries), ONE (main only) or FULL (main + skid). occupancy = 0/1/2 for these states.
- in_ready = (state != FULL) & !freeze. out_valid = (state != EMPTY) & !freeze. out_data = main data at all times.
- in_fire = in_valid & in_ready. out_fire = out_valid & out_ready.
- State transitions, evaluated only when freeze=0 and flush=0:
  - EMPTY: in_fire -> ONE, main <= in_data.
  - ONE, in_fire & out_fire -> ONE, main <= in_data.
  - ONE, in_fire & !out_fire -> FULL, skid <= in_data.
  - ONE, !in_fire & out_fire -> EMPTY.
  - FULL, out_fire -> ONE, main <= skid. in_fire cannot occur in FULL.
  - Any other combination holds the current state.
- Data registers not written in a cycle hold their value. Stale data is not cleared when an entry empties.
- Priority is rst > freeze > flush > normal operation.
- freeze=1: state, data and flush_cnt hold. in_ready=0 and out_valid=0, so no beat is lost or duplicated. A flush asserted during freeze is ignored; hazard control must hold flush until freeze drops.
- flush=1 with freeze=0: next state is EMPTY, both data registers load FLUSH_VAL, and any in_fire or out_fire in that cycle is discarded. Upstream and downstream must treat a handshake in a flush cycle as killed.
- stall_cnt increments in every cycle where freeze=1, or where freeze=0, flush=0, out_valid=1 and out_ready=0. It saturates at 2^CNT_W-1.
- flush_cnt increments in every cycle where flush=1 and freeze=0. It saturates at 2^CNT_W-1.

## Timing
- Reset values: state EMPTY, main = skid = FLUSH_VAL, occupancy=0, in_ready=1 (when freeze=0), out_valid=0, out_data=FLUSH_VAL, stall_cnt=0, flush_cnt=0.
- Reset is asynchronous. Asserting it mid-transfer drops all entries immediately; the first in_fire is possible in the first clk edge after release.
- Latency is 1 cycle: a beat accepted at edge N appears on out_valid/out_data after edge N.
- Throughput is 1 beat per cycle while out_ready=1.
- Back-pressure: with out_ready low, one additional beat is absorbed into skid, then in_ready drops in the cycle after the FULL transition.
- in_ready depends only on registered state and freeze. There is no combinational path from out_ready to in_ready.
- Paths from freeze to in_ready/out_valid are combinational by design and must be constrained as such.
- A flush takes effect at the edge where it is sampled. Outputs show EMPTY/FLUSH_VAL in the following cycle.

## Test plan
- Streaming: DATA_W=64, out_ready=1, feed beats 0x1..0x8 back-to-back. Expect out_data 0x1..0x8 in consecutive cycles, 1-cycle latency, occupancy stays 1, stall_cnt=0.
- Back-pressure: fill with 0xA, then 0xB while out_ready=0. Expect occupancy=2, in_ready=0, stall_cnt incrementing each cycle. Then raise out_ready: expect 0xA, then 0xB, order preserved, no loss or duplicates.
- Flush in FULL: flush while FULL with in_valid=1 carrying 0xC. Next cycle expect occupancy=0, out_valid=0, out_data=FLUSH_VAL, 0xC never emitted, flush_cnt=1.
- Freeze vs flush: assert freeze and flush together for 3 cycles in ONE holding 0xD. Expect out_valid=0, in_ready=0, state unchanged, flush_cnt unchanged, stall_cnt +3. After release, 0xD is emitted.
- Async reset mid-stream: assert rst between edges while FULL. Expect all outputs at their reset values immediately, both counters at 0, and normal acceptance on the first edge after release.
- Saturation: CNT_W=4, hold out_ready=0 with the stage valid for 20 cycles. Expect stall_cnt to stick at 15.

Source files
------------

// File: rtl/pipe_skid_reg.sv
// Elastic pipeline stage register: valid/ready handshake, two-entry skid buffer,
// synchronous flush and freeze, and saturating stall/flush event counters.
module pipe_skid_reg #(
  parameter int                 DATA_W    = 64,
  parameter logic [DATA_W-1:0]  FLUSH_VAL = '0,
  parameter int                 CNT_W     = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  input  logic              flush,
  input  logic              freeze,
  output logic [1:0]        occupancy,
  output logic [CNT_W-1:0]  stall_cnt,
  output logic [CNT_W-1:0]  flush_cnt
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } state_t;

  state_t            state, state_nxt;
  logic [DATA_W-1:0] main_q, main_nxt;
  logic [DATA_W-1:0] skid_q, skid_nxt;
  logic              in_fire, out_fire;
  logic              stall_inc, flush_inc;

  // in_ready is a function of registered state and freeze only, so out_ready
  // never ripples combinationally back up the pipeline.
  assign in_ready  = (state != FULL) && !freeze;
  assign out_valid = (state != EMPTY) && !freeze;
  assign out_data  = main_q;
  assign in_fire   = in_valid && in_ready;
  assign out_fire  = out_valid && out_ready;

  assign stall_inc = freeze || (!flush && out_valid && !out_ready);
  assign flush_inc = flush && !freeze;

  always_comb begin
    // NOTE: every signal written here gets a default first, so no path leaves
    // it unassigned and no latch is inferred.
    state_nxt = state;
    main_nxt  = main_q;
    skid_nxt  = skid_q;
    if (!freeze) begin
      if (flush) begin
        state_nxt = EMPTY;
        main_nxt  = FLUSH_VAL;
        skid_nxt  = FLUSH_VAL;
      end else begin
        unique case (state)
          EMPTY: if (in_fire) begin
            state_nxt = ONE;
            main_nxt  = in_data;
          end
          ONE: begin
            if (in_fire && out_fire) begin
              main_nxt = in_data;
            end else if (in_fire) begin
              state_nxt = FULL;
              skid_nxt  = in_data;
            end else if (out_fire) begin
              state_nxt = EMPTY;
            end
          end
          FULL: if (out_fire) begin
            state_nxt = ONE;
            main_nxt  = skid_q;
          end
          default: state_nxt = EMPTY;
        endcase
      end
    end
  end

  always_comb begin
    occupancy = 2'd0;
    unique case (state)
      ONE:     occupancy = 2'd1;
      FULL:    occupancy = 2'd2;
      default: occupancy = 2'd0;
    endcase
  end

  // NOTE: the data registers are plain flops, not a memory array, so they take
  // the async reset to FLUSH_VAL like the rest of the state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= EMPTY;
      main_q <= FLUSH_VAL;
      skid_q <= FLUSH_VAL;
    end else begin
      // NOTE: sequential state uses non-blocking assignment so every flop
      // samples pre-edge values regardless of statement order.
      state  <= state_nxt;
      main_q <= main_nxt;
      skid_q <= skid_nxt;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      if (stall_inc && (stall_cnt != {CNT_W{1'b1}})) stall_cnt <= stall_cnt + CNT_W'(1);
      if (flush_inc && (flush_cnt != {CNT_W{1'b1}})) flush_cnt <= flush_cnt + CNT_W'(1);
    end
  end

endmodule
